iter_muldiv_alu: RTL and testbench

Parametrised, multicycle successor to the single-cycle datapath ALU.
- Logic, add/sub, shift and set-less-than ops complete in one cycle.
- Mult and div run on an iterative shift-add / restoring-divide engine over WIDTH cycles.
- Results land in dedicated HI/LO registers, as MIPS mfhi/mflo expect.
- Sits in the EX stage; the pipeline stalls on `busy`.

---
 rtl/iter_alu_pkg.sv | 36 +++
 rtl/iter_muldiv_alu_muldiv_engine.sv | 136 +++++++++++++
 rtl/iter_muldiv_alu.sv | 128 ++++++++++++
 tb/tb_iter_muldiv_alu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative mult/div ALU.
//   - 4-bit ALU op codes (OP_*)
//   - mult/div engine FSM state encoding
//   - small width-independent helpers
package iter_alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_NOTA = 4'b1001;
    localparam logic [3:0] OP_MULT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Signed overflow of an addition from the sign bits of its two addends
    // and of the sum. For a subtraction pass the inverted sign of b.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                     input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/iter_muldiv_alu_muldiv_engine.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle over WIDTH cycles. hi/lo are written on the final iteration so they
// are valid in the single FIN cycle where done is high.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         launch request (only sampled in IDLE/FIN)
//   op            ALU op code; OP_DIV selects divide, anything else multiply
//   a, b          operands (multiplicand/dividend, multiplier/divisor)
//   busy          iteration in progress
//   done          one-cycle pulse, hi/lo valid
//   hi, lo        product {hi,lo} or remainder (hi) / quotient (lo)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIN   | hi/lo valid, done=1; a new start is accepted here as in IDLE
module muldiv_engine
    import iter_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, mq_q, opb_q, hi_q, lo_q;
    logic [WIDTH-1:0] acc_n, mq_n;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             is_div, b_zero, last;

    assign is_div = (op == OP_DIV);
    assign b_zero = (b == '0);
    assign last   = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                done = (state_q == ST_FIN);
                if (start) begin
                    if (!is_div)     state_d = ST_MUL;
                    else if (b_zero) state_d = ST_FIN;
                    else             state_d = ST_DIV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                busy = 1'b1;
                if (last) state_d = ST_FIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Multiply: {acc,mq} shifts right, adding b into acc when mq[0] is set.
    // Divide: {acc,mq} shifts left, subtracting b from the partial remainder
    // when it fits; one extra bit on the difference gives a clean borrow flag.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        if (state_q == ST_DIV) begin
            acc_n = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            mq_n  = {mq_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end else begin
            acc_n = mul_sum[WIDTH:1];
            mq_n  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            mq_q  <= '0;
            opb_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        cnt_q <= CNT_W'(WIDTH - 1);
                        acc_q <= '0;
                        mq_q  <= a;
                        opb_q <= b;
                        if (is_div && b_zero) begin
                            hi_q <= a;
                            lo_q <= '1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_q <= acc_n;
                    mq_q  <= mq_n;
                    if (last) begin
                        hi_q <= acc_n;
                        lo_q <= mq_n;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/iter_muldiv_alu.sv
// EX-stage ALU: single-cycle logic/add/sub/shift/slt ops plus an iterative
// mult/div engine writing dedicated HI/LO registers.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        op request, accepted only while busy=0
//   alu_ctrl     op code (see iter_alu_pkg)
//   operand_a/b  operands (rs, rt); shamt: shift amount
//   result       result (single-cycle value, or lo after mult/div)
//   zero         result == 0
//   hi, lo       HI/LO registers
//   busy         mult/div in progress, new start ignored
//   done         one-cycle pulse when result/hi/lo are valid
//   div_by_zero  sticky until next accepted start
//   ovf          (only with ITER_ALU_OVF_EN) signed add/sub overflow
//
// Build option: define ITER_ALU_OVF_EN to add the ovf output.
module iter_muldiv_alu
    import iter_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done,
`ifdef ITER_ALU_OVF_EN
    output logic               ovf,
`endif
    output logic               div_by_zero
);

    logic             accept, op_muldiv, eng_start, eng_busy, eng_done;
    logic             sc_done_q, dbz_q;
    logic [WIDTH-1:0] result_q, alu_val, sum_v, diff_v, eng_hi, eng_lo;

    assign accept    = start && !eng_busy;
    assign op_muldiv = is_muldiv(alu_ctrl);
    assign eng_start = accept && op_muldiv;

    muldiv_engine #(.WIDTH(WIDTH)) u_engine (
        .clk   (clk),
        .rst   (rst),
        .start (eng_start),
        .op    (alu_ctrl),
        .a     (operand_a),
        .b     (operand_b),
        .busy  (eng_busy),
        .done  (eng_done),
        .hi    (eng_hi),
        .lo    (eng_lo)
    );

    assign sum_v  = operand_a + operand_b;
    assign diff_v = operand_a - operand_b;

    always_comb begin
        alu_val = '0;
        case (alu_ctrl)
            OP_ADD:  alu_val = sum_v;
            OP_SUB:  alu_val = diff_v;
            OP_OR:   alu_val = operand_a | operand_b;
            OP_AND:  alu_val = operand_a & operand_b;
            OP_SLT:  alu_val = {{(WIDTH-1){1'b0}},
                                ($signed(operand_a) < $signed(operand_b))};
            OP_SLL:  alu_val = operand_a << shamt;
            OP_SRL:  alu_val = operand_a >> shamt;
            OP_NOTA: alu_val = ~operand_a;
            default: alu_val = '0;
        endcase
    end

`ifdef ITER_ALU_OVF_EN
    logic ovf_v, ovf_q;

    always_comb begin
        ovf_v = 1'b0;
        case (alu_ctrl)
            OP_ADD:  ovf_v = add_ovf(operand_a[WIDTH-1], operand_b[WIDTH-1], sum_v[WIDTH-1]);
            OP_SUB:  ovf_v = add_ovf(operand_a[WIDTH-1], ~operand_b[WIDTH-1], diff_v[WIDTH-1]);
            default: ovf_v = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                      ovf_q <= 1'b0;
        else if (accept && !op_muldiv) ovf_q <= ovf_v;
        else if (eng_done)            ovf_q <= 1'b0;
    end

    assign ovf = ovf_q;
`endif

    // In the engine's done cycle result shows lo directly; result_q copies it
    // at the end of that cycle so the value holds afterwards. A single-cycle
    // op accepted in that same cycle takes precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            sc_done_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            sc_done_q <= accept && !op_muldiv;
            if (accept && !op_muldiv) result_q <= alu_val;
            else if (eng_done)        result_q <= eng_lo;
            if (accept) dbz_q <= (alu_ctrl == OP_DIV) && (operand_b == '0);
        end
    end

    assign result      = eng_done ? eng_lo : result_q;
    assign zero        = (result == '0);
    assign hi          = eng_hi;
    assign lo          = eng_lo;
    assign busy        = eng_busy;
    assign done        = sc_done_q | eng_done;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_muldiv_alu.sv
module tb_iter_muldiv_alu;
    import iter_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  alu_ctrl;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  shamt;
    logic [31:0] result, hi, lo;
    logic        zero, busy, done, div_by_zero;
`ifdef ITER_ALU_OVF_EN
    logic        ovf;
`endif

    iter_muldiv_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_ctrl    (alu_ctrl),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .shamt       (shamt),
        .result      (result),
        .zero        (zero),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
`ifdef ITER_ALU_OVF_EN
        .ovf         (ovf),
`endif
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        upd;
        logic [31:0] hi, lo;
        int          lat;
        logic        dbz;
        logic        ovf;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_v(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] res, input logic upd,
                         input logic [31:0] h, input logic [31:0] l, input int lat,
                         input logic dbz, input logic ov);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh; v.res = res; v.upd = upd;
        v.hi = h; v.lo = l; v.lat = lat; v.dbz = dbz; v.ovf = ov;
        vq.push_back(v);
    endtask

    // Called #1 after an edge; start is seen by the next edge (T).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        start = 1'b1; alu_ctrl = op; operand_a = a; operand_b = b; shamt = sh;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat=1 means done seen right after the accepting edge.
    task automatic wait_done(input string nm, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            chk({nm, "_busy"}, busy, 1);
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_busy_in_done"}, busy, 0);
    endtask

    initial begin
        int lat, seen;
        rst = 1'b1; start = 1'b0; alu_ctrl = '0; operand_a = '0; operand_b = '0; shamt = '0;

        //          op       a             b             sh     res           upd h             l             lat dbz ovf
        add_v(OP_ADD,  32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 0, 0, 0,  1, 0, 1);
        add_v(OP_SUB,  32'd5,        32'd5,        5'd0,  32'h0,        0, 0, 0,  1, 0, 0);
        add_v(OP_SUB,  32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 0, 0, 0,  1, 0, 1);
        add_v(OP_SUB,  32'h0,        32'h1,        5'd0,  32'hFFFFFFFF, 0, 0, 0,  1, 0, 0);
        add_v(OP_ADD,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        0, 0, 0,  1, 0, 0);
        add_v(OP_OR,   32'hF0F00000, 32'h00000F0F, 5'd0,  32'hF0F00F0F, 0, 0, 0,  1, 0, 0);
        add_v(OP_AND,  32'hFFFF0000, 32'h12345678, 5'd0,  32'h12340000, 0, 0, 0,  1, 0, 0);
        add_v(OP_SLT,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        0, 0, 0,  1, 0, 0);
        add_v(OP_SLT,  32'h1,        32'hFFFFFFFF, 5'd0,  32'h0,        0, 0, 0,  1, 0, 0);
        add_v(OP_SLT,  32'h3,        32'h3,        5'd0,  32'h0,        0, 0, 0,  1, 0, 0);
        add_v(OP_SLL,  32'h1,        32'h0,        5'd31, 32'h80000000, 0, 0, 0,  1, 0, 0);
        add_v(OP_SLL,  32'h0000ABCD, 32'h0,        5'd4,  32'h000ABCD0, 0, 0, 0,  1, 0, 0);
        add_v(OP_SRL,  32'h80000000, 32'h0,        5'd31, 32'h1,        0, 0, 0,  1, 0, 0);
        add_v(OP_SRL,  32'h0000ABCD, 32'h0,        5'd0,  32'h0000ABCD, 0, 0, 0,  1, 0, 0);
        add_v(OP_NOTA, 32'h0,        32'h12345678, 5'd0,  32'hFFFFFFFF, 0, 0, 0,  1, 0, 0);
        add_v(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h1,        1, 32'hFFFFFFFE, 32'h1, 33, 0, 0);
        add_v(OP_DIV,  32'd100,      32'd7,        5'd0,  32'd14,       1, 32'd2, 32'd14, 33, 0, 0);
        add_v(OP_DIV,  32'd9,        32'd0,        5'd0,  32'hFFFFFFFF, 1, 32'd9, 32'hFFFFFFFF, 1, 1, 0);
        add_v(OP_ADD,  32'd3,        32'd4,        5'd0,  32'd7,        0, 0, 0,  1, 0, 0);
        add_v(4'b0100, 32'd5,        32'd6,        5'd3,  32'h0,        0, 0, 0,  1, 0, 0);
        add_v(OP_MULT, 32'h00010000, 32'h00010000, 5'd0,  32'h0,        1, 32'h1, 32'h0, 33, 0, 0);
        add_v(OP_DIV,  32'hFFFFFFFF, 32'h10,       5'd0,  32'h0FFFFFFF, 1, 32'hF, 32'h0FFFFFFF, 33, 0, 0);
        add_v(OP_DIV,  32'd7,        32'd9,        5'd0,  32'h0,        1, 32'd7, 32'h0, 33, 0, 0);
        add_v(OP_MULT, 32'h0,        32'h0000FFFF, 5'd0,  32'h0,        1, 32'h0, 32'h0, 33, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_dbz", div_by_zero, 0);

        // Reset with a mult in flight aborts it
        issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        chk("midrst_busy_before", busy, 1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_hilo", {hi, lo}, 0);
        chk("midrst_dbz", div_by_zero, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(posedge clk); #1;
        end
        chk("midrst_no_activity", seen, 0);

        // Vector table
        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            string nm;
            v = vq[i];
            nm = $sformatf("v%0d", i);
            if (v.upd) begin m_hi = v.hi; m_lo = v.lo; end
            issue(v.op, v.a, v.b, v.sh);
            wait_done(nm, lat);
            chk({nm, "_lat"}, lat, v.lat);
            chk({nm, "_result"}, result, v.res);
            chk({nm, "_zero"}, zero, (v.res == 32'h0));
            chk({nm, "_hi"}, hi, m_hi);
            chk({nm, "_lo"}, lo, m_lo);
            chk({nm, "_dbz"}, div_by_zero, v.dbz);
`ifdef ITER_ALU_OVF_EN
            chk({nm, "_ovf"}, ovf, v.ovf);
`endif
            @(posedge clk); #1;
            chk({nm, "_done_pulse"}, done, 0);
            chk({nm, "_result_hold"}, result, v.res);
        end

        // start pulsed while busy is ignored
        issue(OP_MULT, 32'd3, 32'd5, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("ign_busy", busy, 1);
        issue(OP_ADD, 32'd1, 32'd1, 5'd0);
        wait_done("ign", lat);
        chk("ign_lat", lat, 29);
        chk("ign_lo", lo, 15);
        chk("ign_result", result, 15);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        chk("ign_no_extra_done", seen, 0);
        chk("ign_result_hold", result, 15);

        // Back-to-back mult issued in the done cycle
        issue(OP_MULT, 32'd6, 32'd7, 5'd0);
        wait_done("b2b_a", lat);
        chk("b2b_a_lat", lat, 33);
        chk("b2b_a_result", result, 42);
        issue(OP_MULT, 32'd2, 32'hFFFFFFFF, 5'd0);
        chk("b2b_b_accepted", busy, 1);
        chk("b2b_b_result_hold", result, 42);
        wait_done("b2b_b", lat);
        chk("b2b_b_lat", lat, 33);
        chk("b2b_b_hi", hi, 32'h1);
        chk("b2b_b_lo", lo, 32'hFFFFFFFE);
        chk("b2b_b_result", result, 32'hFFFFFFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
